rename_retire_sequencer: RTL and testbench
==========================================

# rename_retire_sequencer

In-order retirement sequencer that feeds the renamer's retire port. It records every issued instruction ID and whether it renamed a destination, tracks writeback completion, and emits one retire packet per cycle in program order so the renamer frees the previous physical register. On a flush it walks the discarded entries youngest-first and emits revert packets, so the renamer restores its speculative rd-to-phys table.

## Interface
- MAX_IDS, 8, number of in-flight IDs; power of two, ≥ 2; ID width ID_W = $clog2(MAX_IDS)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- issue_valid  in  1  instruction issued this cycle
- issue_id  in  ID_W  ID of issued instruction; must equal current tail index
- issue_uses_rd  in  1  instruction was given a renamed destination
- wb_valid  in  1  writeback completion this cycle
- wb_id  in  ID_W  ID completing
- flush  in  1  discard all unretired entries
- retire_valid  out  1  retire/revert packet valid
- retire_id  out  ID_W  ID retired or reverted
- rename_revert  out  1  1 = revert packet (free spec phys reg, restore mapping); 0 = normal retire
- busy  out  1  revert walk in progress; upstream must hold issue
- full  out  1  MAX_IDS entries occupied
- empty  out  1  no entries occupied

## Operation
- State: head and tail pointers, ID_W+1 bits each (extra wrap bit); per-slot uses_rd[MAX_IDS], done[MAX_IDS]; FSM {RUN, REVERT}.
- empty = (head == tail); full = index bits equal and wrap bits differ.
- Issue (RUN, issue_valid, !full, !flush): uses_rd[tail] <= issue_uses_rd, done[tail] <= 0, tail++.
- Writeback (RUN, wb_valid): done[wb_id] <= 1 only if wb_id lies in [head, tail); otherwise ignored.
- Retire (RUN, !empty, done[head]): head++; retire_valid = uses_rd[head], retire_id = head index, rename_revert = 0. Entries without rd pop silently. At most one pop per cycle.
- Flush in RUN: that cycle's retire still occurs; issue that cycle is dropped; next state REVERT if entries remain after the retire, else RUN.
- REVERT: each cycle tail--; retire_valid = uses_rd[tail-1], retire_id = tail-1, rename_revert = 1. Leaves to RUN in the cycle tail reaches head. Writebacks, issues and further flushes are ignored in REVERT. busy = (state == REVERT).
- Issue while full or busy: dropped; simulation assertion fires.
- Wrap-around: pointers wrap modulo 2·MAX_IDS; all comparisons use the wrap bit.

## Timing
- Reset (rst = 0): head = tail = 0, done = 0, uses_rd = 0, state RUN; outputs retire_valid = 0, retire_id = 0, rename_revert = 0, busy = 0, full = 0, empty = 1.
- retire_* are combinational from registered state. wb in cycle N for the head entry gives retire_valid in cycle N+1.
- Issue in cycle N makes the entry visible (empty deasserts) in N+1. Same-cycle wb for that ID is ignored.
- Back-to-back completed entries retire one per cycle.
- Revert of k entries takes exactly k cycles, starting the cycle after flush. busy is high for those k cycles.
- Reset asserted mid-REVERT aborts the walk immediately.

## Configuration
- RENAME_RETIRE_SEQ_PERF_EN defined: adds 32-bit wrapping counters retire_count (retire_valid & !rename_revert) and revert_count (retire_valid & rename_revert), exposed on output ports of the same names, reset to 0.
- Undefined: the ports remain but are tied to 0, and no counter flops are built.

## Test plan
- Reset, then issue IDs 0,1,2 (uses_rd 1,0,1) and wb in order 2,1,0 -> nothing retires until wb 0. Then head 0 retires with retire_id 0, ID 1 pops silently, and retire_id 2 follows, in 3 consecutive cycles, with retire_valid only on 0 and 2.
- Fill 8 entries -> full = 1. A 9th issue is dropped and tail is unchanged. Retire one entry -> full = 0.
- Issue IDs 3,4,5 (all uses_rd) then flush -> busy for 3 cycles, packets 5,4,3 with rename_revert = 1, then RUN and empty = 1.
- Flush in the same cycle head ID 0 is done, with IDs 1,2 pending -> ID 0 retires normally, then reverts 2,1.
- Run 20 issue/retire iterations through pointer wrap -> the ID sequence is continuous modulo 8 and full/empty stay correct.
- With RENAME_RETIRE_SEQ_PERF_EN: the above sequence gives matching retire_count and revert_count; without the macro both read 0.

Source files
------------

// File: rtl/rename_retire_sequencer.sv
// -----------------------------------------------------------------------------
// rename_retire_sequencer
//
// In-order retirement sequencer in front of the renamer's retire port. It
// records every issued instruction ID together with whether it renamed a
// destination, tracks writeback completion, and emits at most one retire
// packet per cycle in program order so the renamer can free the previous
// physical register. On a flush the discarded entries are walked
// youngest-first and revert packets are emitted so the renamer can restore
// its speculative rd-to-phys table.
//
// Parameters:
//   MAX_IDS      in-flight IDs (power of two, >= 2); ID_W = $clog2(MAX_IDS)
//   P_ASSERT_EN  enables the simulation check on illegal issue
//
// Ports:
//   i_clk            clock, all state on the rising edge
//   i_rst_n          asynchronous active-low reset
//   i_issue_valid    instruction issued this cycle
//   i_issue_id       ID of issued instruction (must equal the tail index)
//   i_issue_uses_rd  instruction was given a renamed destination
//   i_wb_valid       writeback completion this cycle
//   i_wb_id          ID completing
//   i_flush          discard all unretired entries
//   o_retire_valid   retire/revert packet valid
//   o_retire_id      ID retired or reverted
//   o_rename_revert  1 = revert packet, 0 = normal retire
//   o_busy           revert walk in progress (upstream must hold issue)
//   o_full           MAX_IDS entries occupied
//   o_empty          no entries occupied
//   o_retire_count   count of normal retire packets (0 unless perf enabled)
//   o_revert_count   count of revert packets (0 unless perf enabled)
//
// Optional feature macro: RENAME_RETIRE_SEQ_PERF_EN builds the two 32-bit
// wrapping packet counters; without it the counter ports are tied to 0.
// -----------------------------------------------------------------------------
module rename_retire_sequencer #(
   parameter int MAX_IDS     = 8,
   parameter bit P_ASSERT_EN = 1'b1,
   localparam int ID_W       = $clog2(MAX_IDS)
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_issue_valid,
   input  logic [ID_W-1:0] i_issue_id,
   input  logic            i_issue_uses_rd,
   input  logic            i_wb_valid,
   input  logic [ID_W-1:0] i_wb_id,
   input  logic            i_flush,
   output logic            o_retire_valid,
   output logic [ID_W-1:0] o_retire_id,
   output logic            o_rename_revert,
   output logic            o_busy,
   output logic            o_full,
   output logic            o_empty,
   output logic [31:0]     o_retire_count,
   output logic [31:0]     o_revert_count
);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   localparam int              PTR_W   = ID_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   typedef enum logic {S_RUN, S_REVERT} state_t;

   state_t             r_state;
   logic [PTR_W-1:0]   r_head;
   logic [PTR_W-1:0]   r_tail;
   logic [MAX_IDS-1:0] r_uses_rd;
   logic [MAX_IDS-1:0] r_done;

   logic [ID_W-1:0]    w_head_idx;
   logic [ID_W-1:0]    w_tail_idx;
   logic [PTR_W-1:0]   w_tail_m1;
   logic [ID_W-1:0]    w_tail_m1_idx;
   logic [PTR_W-1:0]   w_count;
   logic [ID_W-1:0]    w_wb_off;
   logic               w_wb_in_range;
   logic               w_run;
   logic               w_empty;
   logic               w_full;
   logic               w_retire_fire;
   logic               w_issue_fire;
   logic               w_wb_fire;
   logic [PTR_W-1:0]   w_head_next;

   assign w_head_idx    = r_head[ID_W-1:0];
   assign w_tail_idx    = r_tail[ID_W-1:0];
   assign w_tail_m1     = r_tail - PTR_ONE;
   assign w_tail_m1_idx = w_tail_m1[ID_W-1:0];
   assign w_count       = r_tail - r_head;

   assign w_empty = (r_head == r_tail);
   assign w_full  = (r_head[ID_W-1:0] == r_tail[ID_W-1:0]) &&
                    (r_head[ID_W] != r_tail[ID_W]);
   assign w_run   = (r_state == S_RUN);

   // Writeback is accepted only for an occupied slot: its distance from head
   // (modulo MAX_IDS) must be below the occupancy. A wb for the slot being
   // issued in the same cycle sits exactly at the occupancy and is rejected.
   assign w_wb_off      = i_wb_id - w_head_idx;
   assign w_wb_in_range = ({1'b0, w_wb_off} < w_count);

   assign w_retire_fire = w_run && !w_empty && r_done[w_head_idx];
   assign w_issue_fire  = w_run && i_issue_valid && !w_full && !i_flush;
   assign w_wb_fire     = w_run && i_wb_valid && w_wb_in_range;
   assign w_head_next   = r_head + PTR_W'(w_retire_fire);

   assign o_busy  = !w_run;
   assign o_full  = w_full;
   assign o_empty = w_empty;

   // Packets are decoded from registered state only. Entries without a
   // renamed destination still pop, but produce no valid packet.
   always_comb begin
      o_retire_valid  = 1'b0;
      o_retire_id     = w_head_idx;
      o_rename_revert = 1'b0;
      if (w_run) begin
         o_retire_valid = w_retire_fire & r_uses_rd[w_head_idx];
      end else begin
         o_retire_valid  = r_uses_rd[w_tail_m1_idx];
         o_retire_id     = w_tail_m1_idx;
         o_rename_revert = 1'b1;
      end
   end

   // Pointer and walk control.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_RUN;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         case (r_state)
            S_RUN: begin
               r_head <= w_head_next;
               if (w_issue_fire) begin
                  r_tail <= r_tail + PTR_ONE;
               end
               // The flush-cycle retire has already been taken into account
               // through w_head_next; only leftover entries need a walk.
               if (i_flush && (w_head_next != r_tail)) begin
                  r_state <= S_REVERT;
               end
            end
            S_REVERT: begin
               r_tail <= w_tail_m1;
               if (w_tail_m1 == r_head) begin
                  r_state <= S_RUN;
               end
            end
            default: r_state <= S_RUN;
         endcase
      end
   end

   // Per-slot flags. Issue and writeback never target the same slot in one
   // cycle: writeback to the tail slot is out of range unless the queue is
   // full, in which case issue does not fire.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_uses_rd <= '0;
         r_done    <= '0;
      end else begin
         for (int gi = 0; gi < MAX_IDS; gi++) begin
            if (w_issue_fire && (w_tail_idx == ID_W'(gi))) begin
               r_uses_rd[gi] <= i_issue_uses_rd;
               r_done[gi]    <= 1'b0;
            end else if (w_wb_fire && (i_wb_id == ID_W'(gi))) begin
               r_done[gi]    <= 1'b1;
            end
         end
      end
   end

`ifdef RENAME_RETIRE_SEQ_PERF_EN
   logic [31:0] r_retire_count;
   logic [31:0] r_revert_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_retire_count <= '0;
         r_revert_count <= '0;
      end else begin
         if (o_retire_valid && !o_rename_revert) begin
            r_retire_count <= r_retire_count + 32'd1;
         end
         if (o_retire_valid && o_rename_revert) begin
            r_revert_count <= r_revert_count + 32'd1;
         end
      end
   end

   assign o_retire_count = r_retire_count;
   assign o_revert_count = r_revert_count;
`else
   assign o_retire_count = '0;
   assign o_revert_count = '0;
`endif

`ifndef SYNTHESIS
   // Issue must be held while full or walking, and must present the tail ID.
   always_ff @(posedge i_clk) begin
      if (P_ASSERT_EN && i_rst_n && i_issue_valid && !i_flush) begin
         assert (w_run && !w_full)
            else $error("issue while full or during revert walk is dropped");
         assert (!w_run || w_full || (i_issue_id == w_tail_idx))
            else $error("issue_id %0d differs from tail index %0d", i_issue_id, w_tail_idx);
      end
   end
`endif

endmodule

// File: tb/tb_rename_retire_sequencer.sv
// -----------------------------------------------------------------------------
// Directed bench for rename_retire_sequencer. Inputs change 1 time unit after
// the rising edge; outputs are checked in the same half-cycle, before the next
// edge. Expected values are hand-computed constants per step.
// -----------------------------------------------------------------------------
module tb_rename_retire_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        issue_valid;
   logic [2:0]  issue_id;
   logic        issue_uses_rd;
   logic        wb_valid;
   logic [2:0]  wb_id;
   logic        flush;
   logic        retire_valid;
   logic [2:0]  retire_id;
   logic        rename_revert;
   logic        busy;
   logic        full;
   logic        empty;
   logic [31:0] retire_count;
   logic [31:0] revert_count;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   // The illegal-issue check is disabled here because the bench drives a
   // deliberate issue into a full queue.
   rename_retire_sequencer #(.MAX_IDS(8), .P_ASSERT_EN(1'b0)) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_issue_valid   (issue_valid),
      .i_issue_id      (issue_id),
      .i_issue_uses_rd (issue_uses_rd),
      .i_wb_valid      (wb_valid),
      .i_wb_id         (wb_id),
      .i_flush         (flush),
      .o_retire_valid  (retire_valid),
      .o_retire_id     (retire_id),
      .o_rename_revert (rename_revert),
      .o_busy          (busy),
      .o_full          (full),
      .o_empty         (empty),
      .o_retire_count  (retire_count),
      .o_revert_count  (revert_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_pkt(input string tag, input logic v, input logic [2:0] id, input logic rev);
      check({tag, "_valid"},  retire_valid,  v);
      check({tag, "_id"},     retire_id,     id);
      check({tag, "_revert"}, rename_revert, rev);
   endtask

   task automatic chk_flags(input string tag, input logic b, input logic f, input logic e);
      check({tag, "_busy"},  busy,  b);
      check({tag, "_full"},  full,  f);
      check({tag, "_empty"}, empty, e);
   endtask

   task automatic drive(input logic iv, input logic [2:0] iid, input logic urd,
                        input logic wv, input logic [2:0] wid, input logic fl);
      issue_valid   = iv;
      issue_id      = iid;
      issue_uses_rd = urd;
      wb_valid      = wv;
      wb_id         = wid;
      flush         = fl;
   endtask

   task automatic idle();
      drive(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
   endtask

   // One line per cycle: the inputs applied and the packet presented.
   task automatic tick();
      $display("cyc=%0d iv=%0b iid=%0d urd=%0b wv=%0b wid=%0d fl=%0b | rv=%0b rid=%0d rev=%0b busy=%0b full=%0b empty=%0b",
               cyc, issue_valid, issue_id, issue_uses_rd, wb_valid, wb_id, flush,
               retire_valid, retire_id, rename_revert, busy, full, empty);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      tick();
      tick();

      // Reset state.
      chk_pkt("rst", 1'b0, 3'd0, 1'b0);
      chk_flags("rst", 1'b0, 1'b0, 1'b1);
      check("rst_retire_count", retire_count, 32'd0);
      check("rst_revert_count", revert_count, 32'd0);
      rst_n = 1'b1;

      // T1: issue 0,1,2 (uses_rd 1,0,1), writeback 2,1,0.
      drive(1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
      check("t1_empty_before_issue", empty, 1'b1);
      tick();
      drive(1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0);
      check("t1_visible_after_issue", empty, 1'b0);
      tick();
      drive(1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0);
      tick();
      drive(1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0);
      chk_pkt("t1_wait_wb2", 1'b0, 3'd0, 1'b0);
      tick();
      drive(1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0);
      chk_pkt("t1_wait_wb1", 1'b0, 3'd0, 1'b0);
      tick();
      drive(1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0);
      chk_pkt("t1_wait_wb0", 1'b0, 3'd0, 1'b0);
      tick();
      idle();
      chk_pkt("t1_retire0", 1'b1, 3'd0, 1'b0);
      tick();
      chk_pkt("t1_pop1_silent", 1'b0, 3'd1, 1'b0);
      tick();
      chk_pkt("t1_retire2", 1'b1, 3'd2, 1'b0);
      tick();
      chk_pkt("t1_drained", 1'b0, 3'd3, 1'b0);
      chk_flags("t1_drained", 1'b0, 1'b0, 1'b1);

      // T3: issue 3,4,5 (all uses_rd), flush, revert 5,4,3.
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 3'(3 + k), 1'b1, 1'b0, 3'd0, 1'b0);
         tick();
      end
      drive(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
      chk_pkt("t3_flush_cycle", 1'b0, 3'd3, 1'b0);
      check("t3_flush_cycle_busy", busy, 1'b0);
      tick();
      idle();
      for (int k = 0; k < 3; k++) begin
         check($sformatf("t3_busy_%0d", k), busy, 1'b1);
         chk_pkt($sformatf("t3_revert_%0d", k), 1'b1, 3'(5 - k), 1'b1);
         tick();
      end
      chk_flags("t3_after_walk", 1'b0, 1'b0, 1'b1);
      chk_pkt("t3_after_walk", 1'b0, 3'd3, 1'b0);

      // T2: fill 8 entries starting at ID 3, drop a 9th issue.
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 3'(3 + k), 1'b1, 1'b0, 3'd0, 1'b0);
         check($sformatf("t2_fill_full_%0d", k), full, 1'b0);
         tick();
      end
      idle();
      chk_flags("t2_full", 1'b0, 1'b1, 1'b0);
      drive(1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0);
      tick();
      drive(1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0);
      check("t2_full_after_drop", full, 1'b1);
      chk_pkt("t2_head_pending", 1'b0, 3'd3, 1'b0);
      tick();
      idle();
      chk_pkt("t2_retire3", 1'b1, 3'd3, 1'b0);
      check("t2_full_during_pop", full, 1'b1);
      tick();
      chk_flags("t2_after_pop", 1'b0, 1'b0, 1'b0);
      chk_pkt("t2_after_pop", 1'b0, 3'd4, 1'b0);
      // Walking back from ID 2 shows the dropped issue left tail alone.
      drive(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
      tick();
      idle();
      for (int k = 0; k < 7; k++) begin
         check($sformatf("t2_busy_%0d", k), busy, 1'b1);
         chk_pkt($sformatf("t2_revert_%0d", k), 1'b1, 3'(2 - k), 1'b1);
         tick();
      end
      chk_flags("t2_after_walk", 1'b0, 1'b0, 1'b1);
      chk_pkt("t2_after_walk", 1'b0, 3'd4, 1'b0);

      // T4: move head to ID 0 via silent pops, then flush on a done head.
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 3'(4 + k), 1'b0, 1'b0, 3'd0, 1'b0);
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 3'd0, 1'b0, 1'b1, 3'(4 + k), 1'b0);
         check($sformatf("t4_silent_%0d", k), retire_valid, 1'b0);
         tick();
      end
      idle();
      check("t4_silent_last", retire_valid, 1'b0);
      tick();
      check("t4_head0_empty", empty, 1'b1);
      check("t4_head0_id", retire_id, 3'd0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 3'(k), 1'b1, 1'b0, 3'd0, 1'b0);
         tick();
      end
      drive(1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0);
      tick();
      drive(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
      chk_pkt("t4_retire0_on_flush", 1'b1, 3'd0, 1'b0);
      check("t4_flush_busy", busy, 1'b0);
      tick();
      idle();
      check("t4_busy_0", busy, 1'b1);
      chk_pkt("t4_revert2", 1'b1, 3'd2, 1'b1);
      tick();
      check("t4_busy_1", busy, 1'b1);
      chk_pkt("t4_revert1", 1'b1, 3'd1, 1'b1);
      tick();
      chk_flags("t4_after_walk", 1'b0, 1'b0, 1'b1);
      chk_pkt("t4_after_walk", 1'b0, 3'd1, 1'b0);

      // T5: 20 issue/wb/retire rounds across pointer wrap, starting at ID 1.
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 3'(1 + i), i[0], 1'b0, 3'd0, 1'b0);
         check($sformatf("t5_empty_%0d", i), empty, 1'b1);
         tick();
         drive(1'b0, 3'd0, 1'b0, 1'b1, 3'(1 + i), 1'b0);
         chk_flags($sformatf("t5_held_%0d", i), 1'b0, 1'b0, 1'b0);
         tick();
         idle();
         chk_pkt($sformatf("t5_retire_%0d", i), i[0], 3'(1 + i), 1'b0);
         tick();
      end
      check("t5_final_empty", empty, 1'b1);

      // Packet totals: retires 2+1+1+10 = 14, reverts 3+7+2 = 12.
`ifdef RENAME_RETIRE_SEQ_PERF_EN
      check("perf_retire_count", retire_count, 32'd14);
      check("perf_revert_count", revert_count, 32'd12);
`else
      check("perf_retire_count", retire_count, 32'd0);
      check("perf_revert_count", revert_count, 32'd0);
`endif

      // T7: reset asserted in the middle of a revert walk aborts it.
      drive(1'b1, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0);
      tick();
      drive(1'b1, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0);
      tick();
      drive(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1);
      tick();
      idle();
      check("t7_busy", busy, 1'b1);
      chk_pkt("t7_revert6", 1'b1, 3'd6, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_flags("t7_async_rst", 1'b0, 1'b0, 1'b1);
      chk_pkt("t7_async_rst", 1'b0, 3'd0, 1'b0);
      check("t7_rst_retire_count", retire_count, 32'd0);
      check("t7_rst_revert_count", revert_count, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk_flags("t7_after_release", 1'b0, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time bound so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "time limit reached");
   end

endmodule
